// File: rtl/pipe_stream_adapter_if.sv
// rtl/pipe_stream_adapter_if.sv - stream, pipeline-drive and result signals of pipe_stream_adapter
// The adapter connects through the slave modport; its environment uses master.
interface pipe_stream_adapter_if #(
   parameter int DATA_WIDTH = 1
);
   logic                  in_valid;
   logic                  in_ready;
   logic                  in_pred;
   logic [DATA_WIDTH-1:0] in_x;
   logic                  pipe_pred;
   logic [DATA_WIDTH-1:0] pipe_x;
   logic [DATA_WIDTH-1:0] pipe_out;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_data;

   modport master (
      output in_valid, in_pred, in_x, out_ready, pipe_out,
      input  in_ready, out_valid, out_data, pipe_pred, pipe_x
   );

   modport slave (
      input  in_valid, in_pred, in_x, out_ready, pipe_out,
      output in_ready, out_valid, out_data, pipe_pred, pipe_x
   );
endinterface

// File: rtl/pipe_stream_adapter.sv
// rtl/pipe_stream_adapter.sv - valid/ready stream wrapper around a fixed-latency stall-free pipeline
// Optional idle-cycle input gating: PIPE_STREAM_ADAPTER_INPUT_GATE_EN
module pipe_stream_adapter #(
   parameter int DATA_WIDTH = 1,
   parameter int LATENCY    = 2,
   parameter int FIFO_DEPTH = 4
) (
   input logic                  clk,
   input logic                  rst,
   pipe_stream_adapter_if.slave s
);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [CW-1:0] CREDIT_INIT = CW'(FIFO_DEPTH);
   localparam logic [AW-1:0] PTR_LAST    = AW'(FIFO_DEPTH - 1);

   logic [CW-1:0]         credits_q, credits_d;
   logic [CW-1:0]         count_q, count_d;
   logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [LATENCY-1:0]    vld_q, vld_d;
   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

   logic accept;
   logic pop;
   logic wr_en;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == PTR_LAST) ? '0 : p + AW'(1);
   endfunction

   // in_ready depends on registered credits only, never on out_ready
   assign s.in_ready  = (credits_q != '0);
   assign s.out_valid = (count_q != '0);
   assign s.out_data  = s.out_valid ? mem_q[rd_ptr_q] : '0;

   assign accept = s.in_valid & s.in_ready;
   assign pop    = s.out_valid & s.out_ready;
   assign wr_en  = vld_q[LATENCY-1];

`ifdef PIPE_STREAM_ADAPTER_INPUT_GATE_EN
   assign s.pipe_pred = accept & s.in_pred;
   assign s.pipe_x    = accept ? s.in_x : '0;
`else
   assign s.pipe_pred = s.in_pred;
   assign s.pipe_x    = s.in_x;
`endif

   generate
      if (LATENCY == 1) begin : g_vld_single
         assign vld_d = accept;
      end else begin : g_vld_shift
         assign vld_d = {vld_q[LATENCY-2:0], accept};
      end
   endgenerate

   always_comb begin
      credits_d = credits_q;
      count_d   = count_q;
      rd_ptr_d  = rd_ptr_q;
      wr_ptr_d  = wr_ptr_q;

      case ({accept, pop})
         2'b10:   credits_d = credits_q - CW'(1);
         2'b01:   credits_d = credits_q + CW'(1);
         default: credits_d = credits_q;
      endcase

      case ({wr_en, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      if (wr_en) begin
         wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         credits_q <= CREDIT_INIT;
         count_q   <= '0;
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         vld_q     <= '0;
      end else begin
         credits_q <= credits_d;
         count_q   <= count_d;
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
         vld_q     <= vld_d;
      end
   end

   // Storage needs no reset: count gates every read of it
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= s.pipe_out;
      end
   end
endmodule

// File: tb/tb_pipe_stream_adapter.sv
// tb/tb_pipe_stream_adapter.sv - self-checking bench for pipe_stream_adapter
// Pipeline model: out = x ^ pred, delayed by LATENCY cycles.
module tb_pipe_stream_adapter;
   localparam int DW  = 1;
   localparam int LAT = 2;
   localparam int FD  = 4;

   logic clk;
   logic rst;

   pipe_stream_adapter_if #(.DATA_WIDTH(DW)) bus ();

   pipe_stream_adapter #(
      .DATA_WIDTH(DW),
      .LATENCY   (LAT),
      .FIFO_DEPTH(FD)
   ) dut (
      .clk(clk),
      .rst(rst),
      .s  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [DW-1:0] pl [LAT];
   always_ff @(posedge clk) begin
      pl[0] <= bus.pipe_x ^ {DW{bus.pipe_pred}};
      for (int i = 1; i < LAT; i++) pl[i] <= pl[i-1];
   end
   assign bus.pipe_out = pl[LAT-1];

   typedef struct {
      logic [DW-1:0] d;
      int            land;
   } flight_t;

   typedef struct {
      logic          v;
      logic          p;
      logic [DW-1:0] x;
      logic          r;
      logic          e_ir;
      logic          e_ov;
      logic [DW-1:0] e_od;
   } vec_t;

   flight_t       m_fly[$];
   logic [DW-1:0] m_fifo[$];
   int            m_credits;
   int            cyc;

   int n_err;
   int n_checks;

   logic          s_ir, s_ov, s_pp;
   logic [DW-1:0] s_od, s_px;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_fly.delete();
      m_fifo.delete();
      m_credits = FD;
   endtask

   task automatic step(input logic v, input logic p, input logic [DW-1:0] x,
                       input logic r, input logic rs);
      logic          e_ir, e_ov, e_acc, e_pop, e_pp;
      logic [DW-1:0] e_od, e_px;
      flight_t       f;
      bus.in_valid  = v;
      bus.in_pred   = p;
      bus.in_x      = x;
      bus.out_ready = r;
      rst           = rs;
      @(negedge clk);
      e_ir  = (m_credits != 0);
      e_ov  = (m_fifo.size() != 0);
      e_od  = e_ov ? m_fifo[0] : '0;
      e_acc = v & e_ir;
      e_pop = e_ov & r;
`ifdef PIPE_STREAM_ADAPTER_INPUT_GATE_EN
      e_px = e_acc ? x : '0;
      e_pp = e_acc & p;
`else
      e_px = x;
      e_pp = p;
`endif
      s_ir = bus.in_ready;
      s_ov = bus.out_valid;
      s_od = bus.out_data;
      s_px = bus.pipe_x;
      s_pp = bus.pipe_pred;
      chk("model_in_ready", int'(s_ir), int'(e_ir));
      chk("model_out_valid", int'(s_ov), int'(e_ov));
      chk("model_out_data", int'(s_od), int'(e_od));
      chk("model_pipe_x", int'(s_px), int'(e_px));
      chk("model_pipe_pred", int'(s_pp), int'(e_pp));
      @(posedge clk);
      if (rs) begin
         model_reset();
      end else begin
         if (e_pop) void'(m_fifo.pop_front());
         while (m_fly.size() != 0) begin
            if (m_fly[0].land != cyc) break;
            f = m_fly.pop_front();
            m_fifo.push_back(f.d);
         end
         if (e_acc) begin
            f.d    = x ^ {DW{p}};
            f.land = cyc + LAT;
            m_fly.push_back(f);
         end
         m_credits = m_credits - int'(e_acc) + int'(e_pop);
      end
      cyc++;
      #1;
   endtask

   vec_t          tbl[9];
   logic [DW-1:0] popped[$];
   int            acc_cnt;
   int            pop_cnt;
   logic          prev_first_pop;

   initial begin
      n_err    = 0;
      n_checks = 0;
      cyc      = 0;
      bus.in_valid  = 1'b0;
      bus.in_pred   = 1'b0;
      bus.in_x      = '0;
      bus.out_ready = 1'b0;
      rst           = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      model_reset();

      // reset state
      step(0, 0, 0, 0, 0);
      chk("rst_in_ready", int'(s_ir), 1);
      chk("rst_out_valid", int'(s_ov), 0);
      chk("rst_out_data", int'(s_od), 0);

      // single items: x=1 pred=0 -> 1, then x=0 pred=1 -> 1, earliest at +3
      tbl[0] = '{v:1, p:0, x:1, r:1, e_ir:1, e_ov:0, e_od:0};
      tbl[1] = '{v:0, p:0, x:0, r:1, e_ir:1, e_ov:0, e_od:0};
      tbl[2] = '{v:0, p:0, x:0, r:1, e_ir:1, e_ov:0, e_od:0};
      tbl[3] = '{v:0, p:0, x:0, r:1, e_ir:1, e_ov:1, e_od:1};
      tbl[4] = '{v:0, p:0, x:0, r:1, e_ir:1, e_ov:0, e_od:0};
      tbl[5] = '{v:1, p:1, x:0, r:1, e_ir:1, e_ov:0, e_od:0};
      tbl[6] = '{v:0, p:0, x:0, r:1, e_ir:1, e_ov:0, e_od:0};
      tbl[7] = '{v:0, p:0, x:0, r:1, e_ir:1, e_ov:0, e_od:0};
      tbl[8] = '{v:0, p:0, x:0, r:1, e_ir:1, e_ov:1, e_od:1};
      for (int i = 0; i < 9; i++) begin
         step(tbl[i].v, tbl[i].p, tbl[i].x, tbl[i].r, 0);
         chk($sformatf("vec%0d_in_ready", i), int'(s_ir), int'(tbl[i].e_ir));
         chk($sformatf("vec%0d_out_valid", i), int'(s_ov), int'(tbl[i].e_ov));
         chk($sformatf("vec%0d_out_data", i), int'(s_od), int'(tbl[i].e_od));
      end

      // streaming 10 items back-to-back
      popped.delete();
      for (int i = 0; i < 14; i++) begin
         if (i < 10) step(1, 0, DW'(i % 2 == 0), 1, 0);
         else        step(0, 0, 0, 1, 0);
         if (i < 10) chk("stream_in_ready", int'(s_ir), 1);
         if (s_ov) popped.push_back(s_od);
      end
      chk("stream_pop_count", popped.size(), 10);
      for (int i = 0; i < popped.size(); i++)
         chk($sformatf("stream_data%0d", i), int'(popped[i]), (i % 2 == 0) ? 1 : 0);

      // back-pressure: exactly FD accepts, then drain in order
      acc_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         step(1, 0, DW'($urandom), 0, 0);
         if (s_ir) acc_cnt++;
      end
      chk("bp_accepts", acc_cnt, FD);
      chk("bp_in_ready_low", int'(s_ir), 0);
      pop_cnt = 0;
      prev_first_pop = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step(0, 0, 0, 1, 0);
         if (prev_first_pop) chk("bp_ready_after_pop", int'(s_ir), 1);
         prev_first_pop = 1'b0;
         if (s_ov) begin
            if (pop_cnt == 0) begin
               chk("bp_ready_at_first_pop", int'(s_ir), 0);
               prev_first_pop = 1'b1;
            end
            pop_cnt++;
         end
      end
      chk("bp_pop_count", pop_cnt, FD);

      // accept and pop together at credits=1
      for (int i = 0; i < 3; i++) step(1, 0, DW'($urandom), 0, 0);
      step(1, 0, 1, 1, 0);
      chk("c1_ready_both", int'(s_ir), 1);
      chk("c1_valid_both", int'(s_ov), 1);
      step(1, 0, 0, 0, 0);
      chk("c1_credit_kept", int'(s_ir), 1);
      step(0, 0, 0, 0, 0);
      chk("c1_credit_zero", int'(s_ir), 0);
      for (int i = 0; i < 20; i++)
         step(logic'($urandom_range(1)), logic'($urandom_range(1)), DW'($urandom),
              logic'($urandom_range(1)), 0);
      for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 0);

      // reset with 2 items in the FIFO and 2 in the pipeline
      for (int i = 0; i < 4; i++) step(1, 0, 1, 0, 0);
      step(0, 0, 0, 0, 1);
      chk("mr_valid_before", int'(s_ov), 1);
      step(0, 0, 0, 1, 0);
      chk("mr_out_valid", int'(s_ov), 0);
      chk("mr_in_ready", int'(s_ir), 1);
      for (int i = 0; i < 6; i++) begin
         step(0, 0, 0, 1, 0);
         chk("mr_no_stale", int'(s_ov), 0);
      end
      acc_cnt = 0;
      for (int i = 0; i < 5; i++) begin
         step(1, 0, 0, 0, 0);
         if (s_ir) acc_cnt++;
      end
      chk("mr_full_credits", acc_cnt, FD);
      for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 0);

      // idle-cycle pipeline drive
      step(0, 0, 1, 1, 0);
`ifdef PIPE_STREAM_ADAPTER_INPUT_GATE_EN
      chk("idle_pipe_x", int'(s_px), 0);
`else
      chk("idle_pipe_x", int'(s_px), 1);
`endif
      step(1, 0, 1, 1, 0);
      chk("acc_pipe_x", int'(s_px), 1);

      // random traffic with occasional reset
      for (int i = 0; i < 400; i++)
         step(logic'($urandom_range(3) != 0), logic'($urandom_range(1)), DW'($urandom),
              logic'($urandom_range(2) != 0), logic'($urandom_range(99) == 0));

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
